updi_target_responder: RTL

- Byte-level UPDI target (device-side) responder; the other end of the programmer link carried by the UART FIFO block.
- Sits behind a UART FIFO instance: pops received bytes from its RX FIFO, decodes SYNCH + instruction frames, and pushes response bytes into its TX FIFO.
- Holds a 16-byte control/status (CS) register file and a small data memory.
- Used as a synthesizable loopback target for bench and on-board self-test of the programmer.

---
 rtl/updi_target_responder.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/updi_target_responder.sv
// UPDI target-side byte responder: pops frames from a UART RX FIFO, decodes
// SYNCH + LDCS/STCS/LDS/STS, keeps a 16-byte CS file and a small data memory,
// and pushes response bytes into the UART TX FIFO.
module updi_target_responder #(
   parameter int unsigned MEM_DEPTH      = 64,
   parameter logic [7:0]  CS0_RESET      = 8'h30,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter bit          ECHO_DISCARD   = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [7:0] rx_data_i,
   input  logic       rx_fifo_empty_i,
   output logic       rx_fifo_rd_en_o,
   output logic [7:0] tx_data_o,
   output logic       tx_fifo_wr_en_o,
   input  logic       tx_fifo_full_i,
   output logic       busy_o,
   output logic       sync_err_o,
   output logic       instr_err_o,
   output logic       timeout_o
);

   localparam int unsigned AddrW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int unsigned CntW  = $clog2(TIMEOUT_CYCLES);
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {StSync, StInstr, StAddr, StData, StTx} state_e;

   state_e          state_q, state_d;
   state_e          nxt_q, nxt_d;       // state to enter once the pending TX byte is pushed
   logic [7:0]      tx_data_q, tx_data_d;
   logic [7:0]      addr_q, addr_d;
   logic [3:0]      idx_q, idx_d;
   logic            is_cs_q, is_cs_d;   // frame is STCS
   logic            is_st_q, is_st_d;   // frame is STS (else LDS)
   logic [7:0]      cs_q [16];
   logic [7:0]      cs_d [16];
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      echo_q, echo_d;
   logic            run_q;              // low for the first cycle out of reset: keeps outputs quiet

   logic [7:0]      mem_q [MEM_DEPTH];
   logic            mem_we;
   logic [7:0]      mem_wdata;

   logic            avail, pop_req, push_req, discard;
   logic            sync_err_det, instr_err_det, timeout_det;
   logic            rx_in_range, addr_in_range;

   assign rx_in_range   = ({24'd0, rx_data_i} < MEM_DEPTH);
   assign addr_in_range = ({24'd0, addr_q} < MEM_DEPTH);

   // State and datapath registers; async reset abandons any frame in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StSync;
         nxt_q     <= StSync;
         tx_data_q <= 8'h00;
         addr_q    <= 8'h00;
         idx_q     <= 4'h0;
         is_cs_q   <= 1'b0;
         is_st_q   <= 1'b0;
         cnt_q     <= '0;
         echo_q    <= 3'd0;
         run_q     <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            cs_q[i] <= (i == 0) ? CS0_RESET : 8'h00;
         end
      end else begin
         state_q   <= state_d;
         nxt_q     <= nxt_d;
         tx_data_q <= tx_data_d;
         addr_q    <= addr_d;
         idx_q     <= idx_d;
         is_cs_q   <= is_cs_d;
         is_st_q   <= is_st_d;
         cnt_q     <= cnt_d;
         echo_q    <= echo_d;
         run_q     <= 1'b1;
         cs_q      <= cs_d;
      end
   end

   // Data memory write port; contents are deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         mem_q[addr_q[AddrW-1:0]] <= mem_wdata;
      end
   end

   // Next-state: byte consumption, frame decode, echo bookkeeping and timeout.
   always_comb begin
      state_d       = state_q;
      nxt_d         = nxt_q;
      tx_data_d     = tx_data_q;
      addr_d        = addr_q;
      idx_d         = idx_q;
      is_cs_d       = is_cs_q;
      is_st_d       = is_st_q;
      cs_d          = cs_q;
      cnt_d         = cnt_q;
      echo_d        = echo_q;
      pop_req       = 1'b0;
      push_req      = 1'b0;
      discard       = 1'b0;
      sync_err_det  = 1'b0;
      instr_err_det = 1'b0;
      timeout_det   = 1'b0;
      mem_we        = 1'b0;
      mem_wdata     = rx_data_i;
      avail         = run_q && !rx_fifo_empty_i;

      if (state_q == StTx) begin
         if (!tx_fifo_full_i) begin
            push_req = 1'b1;
            state_d  = nxt_q;
         end
      end else if (avail && (echo_q != 3'd0)) begin
         // Our own transmitted byte reflected on the single wire.
         pop_req = 1'b1;
         discard = 1'b1;
      end else if (avail) begin
         pop_req = 1'b1;
         unique case (state_q)
            StSync: begin
               if (rx_data_i == 8'h55) state_d = StInstr;
               else                    sync_err_det = 1'b1;
            end
            StInstr: begin
               if (rx_data_i[7:4] == 4'h8) begin
                  tx_data_d = cs_q[rx_data_i[3:0]];
                  nxt_d     = StSync;
                  state_d   = StTx;
               end else if (rx_data_i[7:4] == 4'hC) begin
                  is_cs_d = 1'b1;
                  idx_d   = rx_data_i[3:0];
                  state_d = StData;
               end else if (rx_data_i == 8'h00 || rx_data_i == 8'h40) begin
                  is_cs_d = 1'b0;
                  is_st_d = rx_data_i[6];
                  state_d = StAddr;
               end else begin
                  instr_err_det = 1'b1;
                  state_d       = StSync;
               end
            end
            StAddr: begin
               addr_d  = rx_data_i;
               state_d = StTx;
               if (is_st_q) begin
                  tx_data_d = 8'h40;
                  nxt_d     = StData;
               end else begin
                  tx_data_d = rx_in_range ? mem_q[rx_data_i[AddrW-1:0]] : 8'h00;
                  nxt_d     = StSync;
               end
            end
            StData: begin
               if (is_cs_q) begin
                  cs_d[idx_q] = rx_data_i;
                  state_d     = StSync;
               end else begin
                  mem_we    = addr_in_range;
                  tx_data_d = 8'h40;
                  nxt_d     = StSync;
                  state_d   = StTx;
               end
            end
            default: ;
         endcase
      end else if (state_q != StSync && cnt_q == CntMax) begin
         timeout_det = 1'b1;
         state_d     = StSync;
      end

      // Idle counter: cleared by any pop or while hunting for SYNCH, frozen in TX.
      if (pop_req || state_q == StSync || timeout_det) begin
         cnt_d = '0;
      end else if (state_q != StTx) begin
         cnt_d = cnt_q + CntW'(1);
      end

      if (ECHO_DISCARD && push_req && !discard) begin
         if (echo_q != 3'd7) echo_d = echo_q + 3'd1;
      end else if (discard && !(ECHO_DISCARD && push_req)) begin
         echo_d = echo_q - 3'd1;
      end
   end

   // Outputs: FIFO handshakes and one-cycle event pulses.
   always_comb begin
      rx_fifo_rd_en_o = pop_req;
      tx_fifo_wr_en_o = push_req;
      tx_data_o       = tx_data_q;
      busy_o          = (state_q != StSync) || (echo_q != 3'd0);
      sync_err_o      = sync_err_det;
      instr_err_o     = instr_err_det;
      timeout_o       = timeout_det;
   end

endmodule
